// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester IDs and default burst length.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    DONE
  } arbState_t;

  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  localparam int DEFAULT_BEATS = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break between icache and dcache requests.
// MEM_ARBITER_FIXED_PRIO_EN selects fixed dcache priority instead of round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic iReq,
  input  logic dReq,
  input  logic lastGnt,
  output logic winner
);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign winner = dReq ? DCACHE : ICACHE;
`else
  always_comb begin
    winner = ICACHE;
    // On a tie, the side that was not served last gets the bus.
    if (iReq && dReq) begin
      winner = ~lastGnt;
    end else if (dReq) begin
      winner = DCACHE;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto one burst memory port.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed dcache priority; default is round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = DEFAULT_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_cmd_ready,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              stall
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  arbState_t         state;
  logic              owner;
  logic              rnwReg;
  logic [ADDR_W-1:0] addrReg;
  logic [CNT_W-1:0]  beatCnt;
  logic              lastGnt;
  logic              winner;

  mem_arb_pick uPick (
    .iReq   (i_req),
    .dReq   (d_req),
    .lastGnt(lastGnt),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= ICACHE;
      rnwReg  <= 1'b1;
      addrReg <= '0;
      beatCnt <= '0;
      lastGnt <= ICACHE;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner   <= winner;
            addrReg <= (winner == DCACHE) ? d_addr : i_addr;
            rnwReg  <= !((winner == DCACHE) && d_we);
            beatCnt <= '0;
            state   <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            state <= rnwReg ? READ : WRITE;
          end
        end
        WRITE: begin
          if (mem_wready) begin
            beatCnt <= beatCnt + 1'b1;
            if (beatCnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        READ: begin
          if (mem_rvalid) begin
            beatCnt <= beatCnt + 1'b1;
            if (beatCnt == LAST_BEAT) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          lastGnt <= owner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register; data paths are forced to zero outside their phase.
  logic inCmd, inWrite, inRead, inDone;
  assign inCmd   = (state == CMD);
  assign inWrite = (state == WRITE);
  assign inRead  = (state == READ);
  assign inDone  = (state == DONE);

  assign mem_cmd_valid = inCmd;
  assign mem_cmd_rnw   = inCmd && rnwReg;
  assign mem_cmd_addr  = inCmd ? (addrReg & ALIGN_MASK) : '0;

  assign mem_wvalid = inWrite;
  assign mem_wdata  = inWrite ? d_wdata : '0;
  assign d_wready   = inWrite && mem_wready;

  assign i_rvalid = inRead && (owner == ICACHE) && mem_rvalid;
  assign d_rvalid = inRead && (owner == DCACHE) && mem_rvalid;
  assign i_rdata  = (inRead && (owner == ICACHE)) ? mem_rdata : '0;
  assign d_rdata  = (inRead && (owner == DCACHE)) ? mem_rdata : '0;

  assign i_done = inDone && (owner == ICACHE);
  assign d_done = inDone && (owner == DCACHE);

  // Gated by rst so the core is released while reset is held.
  assign stall = !rst && (i_req || d_req) && !inDone;

endmodule
